// File: rtl/baccarat_round_ctrl_if.sv
// Card/score datapath link: controller issues load strobes, datapath returns scores.
interface baccarat_round_ctrl_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       clear_hands;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3, clear_hands
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3, clear_hands
    );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Multi-round baccarat dealer: deal sequencing, third-card rules, settlement,
// optional auto-restart and saturating win/tie/round tallies.
module baccarat_round_ctrl #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned AUTO_RESTART = 0,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic                  slow_clock,
    input  logic                  resetb,
    input  logic                  start,
    input  logic                  tally_clr,
    baccarat_round_ctrl_if.master dp,
    output logic                  player_win_light,
    output logic                  dealer_win_light,
    output logic                  busy,
    output logic                  round_done,
    output logic [CNT_W-1:0]      player_wins,
    output logic [CNT_W-1:0]      dealer_wins,
    output logic [CNT_W-1:0]      ties,
    output logic [CNT_W-1:0]      rounds
);

    localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLEAR  = 4'd1,
        S_P1     = 4'd2,
        S_D1     = 4'd3,
        S_P2     = 4'd4,
        S_D2     = 4'd5,
        S_EVAL   = 4'd6,
        S_BANKER = 4'd7,
        S_SETTLE = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              ld_p1, ld_p2, ld_p3, ld_d1, ld_d2, ld_d3, clr_hands;
    logic              lights_clr;
    logic              banker_draw;
    logic              natural_hand;
    logic              player_stands;
    logic              dealer_low;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign natural_hand  = (dp.pscore >= 4'd8) || (dp.dscore >= 4'd8);
    assign player_stands = (dp.pscore >= 4'd6);
    assign dealer_low    = (dp.dscore <= 4'd5);

    // Banker third-card table, indexed by banker two-card score and player's third card
    always_comb begin
        banker_draw = 1'b0;
        case (dp.dscore)
            4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
            4'd3:    banker_draw = (dp.pcard3 != 4'd8);
            4'd4:    banker_draw = (dp.pcard3 >= 4'd2) && (dp.pcard3 <= 4'd7);
            4'd5:    banker_draw = (dp.pcard3 >= 4'd4) && (dp.pcard3 <= 4'd7);
            4'd6:    banker_draw = (dp.pcard3 >= 4'd6) && (dp.pcard3 <= 4'd7);
            default: banker_draw = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_p1      = 1'b0;
        ld_p2      = 1'b0;
        ld_p3      = 1'b0;
        ld_d1      = 1'b0;
        ld_d2      = 1'b0;
        ld_d3      = 1'b0;
        clr_hands  = 1'b0;
        lights_clr = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = S_CLEAR;
            S_CLEAR: begin
                clr_hands  = 1'b1;
                lights_clr = 1'b1;
                state_next = S_P1;
            end
            S_P1: begin ld_p1 = 1'b1; state_next = S_D1; end
            S_D1: begin ld_d1 = 1'b1; state_next = S_P2; end
            S_P2: begin ld_p2 = 1'b1; state_next = S_D2; end
            S_D2: begin ld_d2 = 1'b1; state_next = S_EVAL; end
            S_EVAL: begin
                if (natural_hand) begin
                    state_next = S_SETTLE;
                end else if (player_stands) begin
                    ld_d3      = dealer_low;
                    state_next = S_SETTLE;
                end else begin
                    ld_p3      = 1'b1;
                    state_next = S_BANKER;
                end
            end
            S_BANKER: begin
                ld_d3      = banker_draw;
                state_next = S_SETTLE;
            end
            S_SETTLE: state_next = S_DONE;
            S_DONE: begin
                if (AUTO_RESTART != 0) begin
                    if (hold_cnt == '0) state_next = S_CLEAR;
                end else if (start) begin
                    state_next = S_CLEAR;
                end
            end
            default: begin
                lights_clr = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    assign dp.load_pcard1 = ld_p1;
    assign dp.load_pcard2 = ld_p2;
    assign dp.load_pcard3 = ld_p3;
    assign dp.load_dcard1 = ld_d1;
    assign dp.load_dcard2 = ld_d2;
    assign dp.load_dcard3 = ld_d3;
    assign dp.clear_hands = clr_hands;

    // Status flags registered from the next state so they align with the state register
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            busy       <= 1'b0;
            round_done <= 1'b0;
        end else begin
            busy       <= (state_next != S_IDLE) && (state_next != S_DONE);
            round_done <= (state_next == S_DONE);
        end
    end

    // Hold counter counts HOLD_CYCLES-1 down to 0 while in DONE
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)                                   hold_cnt <= '0;
        else if (state == S_SETTLE)                    hold_cnt <= HOLD_LOAD;
        else if ((state == S_DONE) && (hold_cnt != '0)) hold_cnt <= hold_cnt - HOLD_W'(1);
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (lights_clr) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (state == S_SETTLE) begin
            player_win_light <= (dp.pscore >= dp.dscore);
            dealer_win_light <= (dp.dscore >= dp.pscore);
        end
    end

    // Tally clear beats a coincident settle increment
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_wins <= '0;
            dealer_wins <= '0;
            ties        <= '0;
            rounds      <= '0;
        end else if (tally_clr) begin
            player_wins <= '0;
            dealer_wins <= '0;
            ties        <= '0;
            rounds      <= '0;
        end else if (state == S_SETTLE) begin
            rounds <= sat_inc(rounds);
            if (dp.pscore > dp.dscore)      player_wins <= sat_inc(player_wins);
            else if (dp.dscore > dp.pscore) dealer_wins <= sat_inc(dealer_wins);
            else                            ties        <= sat_inc(ties);
        end
    end

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: table of rounds on a 2-bit-tally instance,
// plus directed sequences for auto-restart, chaining, mid-round reset and tally clear.
module tb_baccarat_round_ctrl;

    logic       slow_clock;
    logic       resetb;
    logic       start_a, start_b;
    logic       tally_clr_a, tally_clr_b;
    logic       pl_a, dl_a, busy_a, done_a;
    logic       pl_b, dl_b, busy_b, done_b;
    logic [1:0] pw_a, dw_a, ti_a, rn_a;
    logic [7:0] pw_b, dw_b, ti_b, rn_b;
    logic [6:0] strb_a;

    int total = 0;
    int bad   = 0;

    baccarat_round_ctrl_if dpa ();
    baccarat_round_ctrl_if dpb ();

    baccarat_round_ctrl #(.CNT_W(2), .AUTO_RESTART(0), .HOLD_CYCLES(4)) dut_a (
        .slow_clock(slow_clock), .resetb(resetb), .start(start_a), .tally_clr(tally_clr_a),
        .dp(dpa), .player_win_light(pl_a), .dealer_win_light(dl_a), .busy(busy_a),
        .round_done(done_a), .player_wins(pw_a), .dealer_wins(dw_a), .ties(ti_a), .rounds(rn_a)
    );

    baccarat_round_ctrl #(.CNT_W(8), .AUTO_RESTART(1), .HOLD_CYCLES(4)) dut_b (
        .slow_clock(slow_clock), .resetb(resetb), .start(start_b), .tally_clr(tally_clr_b),
        .dp(dpb), .player_win_light(pl_b), .dealer_win_light(dl_b), .busy(busy_b),
        .round_done(done_b), .player_wins(pw_b), .dealer_wins(dw_b), .ties(ti_b), .rounds(rn_b)
    );

    assign strb_a = {dpa.load_pcard1, dpa.load_dcard1, dpa.load_pcard2, dpa.load_dcard2,
                     dpa.load_pcard3, dpa.load_dcard3, dpa.clear_hands};

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    typedef struct {
        logic [3:0] p2, d2, c3, p3, d3;
        bit         draw_p, draw_d;
        int         len;
        bit         pl, dl;
    } vec_t;

    vec_t vecs[12];
    int   e_pw, e_dw, e_ti, e_rn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v < 3) ? v + 1 : v;
    endfunction

    // Drive one round on dut_a acting as the datapath, checking strobes cycle by cycle
    task automatic run_round(input vec_t v);
        int  len       = 0;
        bit  done      = 1'b0;
        bit  saw_p3    = 1'b0;
        bit  saw_d3    = 1'b0;
        int  multi     = 0;
        int  order_err = 0;
        int  clr_cnt   = 0;
        bit  upd_p, upd_d;
        dpa.pscore = v.p2;
        dpa.dscore = v.d2;
        dpa.pcard3 = v.c3;
        start_a    = 1'b1;
        @(posedge slow_clock); #1;
        start_a = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge slow_clock);
            upd_p = 1'b0;
            upd_d = 1'b0;
            if ($countones(strb_a[6:1]) > 1) multi++;
            if (dpa.clear_hands) clr_cnt++;
            if (dpa.load_pcard3) begin saw_p3 = 1'b1; upd_p = 1'b1; end
            if (dpa.load_dcard3) begin saw_d3 = 1'b1; upd_d = 1'b1; end
            case (cyc)
                1: if (!dpa.clear_hands) order_err++;
                2: if (!dpa.load_pcard1) order_err++;
                3: if (!dpa.load_dcard1) order_err++;
                4: if (!dpa.load_pcard2) order_err++;
                5: if (!dpa.load_dcard2) order_err++;
                default: ;
            endcase
            if (done_a) begin
                done = 1'b1;
                len  = cyc - 1;
                break;
            end
            @(posedge slow_clock); #1;
            if (upd_p) dpa.pscore = v.p3;
            if (upd_d) dpa.dscore = v.d3;
        end
        if (v.pl && v.dl)  e_ti = sat3(e_ti);
        else if (v.pl)     e_pw = sat3(e_pw);
        else               e_dw = sat3(e_dw);
        e_rn = sat3(e_rn);
        check("round_reached_done", 32'(done), 32'd1);
        check("round_len", 32'(len), 32'(v.len));
        check("draw_pcard3", 32'(saw_p3), 32'(v.draw_p));
        check("draw_dcard3", 32'(saw_d3), 32'(v.draw_d));
        check("multi_strobe", 32'(multi), 32'd0);
        check("deal_order", 32'(order_err), 32'd0);
        check("clear_pulses", 32'(clr_cnt), 32'd1);
        check("player_light", 32'(pl_a), 32'(v.pl));
        check("dealer_light", 32'(dl_a), 32'(v.dl));
        check("player_wins", 32'(pw_a), 32'(e_pw));
        check("dealer_wins", 32'(dw_a), 32'(e_dw));
        check("ties", 32'(ti_a), 32'(e_ti));
        check("rounds", 32'(rn_a), 32'(e_rn));
    endtask

    initial begin
        int hold;
        //         p2    d2    c3    p3    d3   dp dd len pl dl
        vecs[0]  = '{4'd9, 4'd3, 4'd0, 4'd9, 4'd3, 0, 0, 7, 1, 0};
        vecs[1]  = '{4'd4, 4'd3, 4'd8, 4'd2, 4'd3, 1, 0, 8, 0, 1};
        vecs[2]  = '{4'd7, 4'd5, 4'd0, 4'd7, 4'd7, 0, 1, 7, 1, 1};
        vecs[3]  = '{4'd6, 4'd7, 4'd0, 4'd6, 4'd7, 0, 0, 7, 0, 1};
        vecs[4]  = '{4'd3, 4'd6, 4'd6, 4'd9, 4'd2, 1, 1, 8, 1, 0};
        vecs[5]  = '{4'd0, 4'd2, 4'd9, 4'd9, 4'd7, 1, 1, 8, 1, 0};
        vecs[6]  = '{4'd5, 4'd4, 4'd1, 4'd6, 4'd4, 1, 0, 8, 1, 0};
        vecs[7]  = '{4'd2, 4'd5, 4'd3, 4'd5, 4'd5, 1, 0, 8, 1, 1};
        vecs[8]  = '{4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 0, 0, 7, 0, 1};
        vecs[9]  = '{4'd5, 4'd7, 4'd7, 4'd2, 4'd7, 1, 0, 8, 0, 1};
        vecs[10] = '{4'd6, 4'd3, 4'd0, 4'd6, 4'd5, 0, 1, 7, 1, 0};
        vecs[11] = '{4'd1, 4'd3, 4'd2, 4'd3, 4'd7, 1, 1, 8, 0, 1};
        e_pw = 0; e_dw = 0; e_ti = 0; e_rn = 0;

        resetb      = 1'b0;
        start_a     = 1'b0;
        start_b     = 1'b0;
        tally_clr_a = 1'b0;
        tally_clr_b = 1'b0;
        dpa.pscore = 4'd0; dpa.dscore = 4'd0; dpa.pcard3 = 4'd0;
        dpb.pscore = 4'd0; dpb.dscore = 4'd0; dpb.pcard3 = 4'd0;
        repeat (2) @(negedge slow_clock);
        check("reset_strobes", 32'(strb_a), 32'd0);
        check("reset_flags", 32'({pl_a, dl_a, busy_a, done_a}), 32'd0);
        check("reset_tallies", 32'({pw_a, dw_a, ti_a, rn_a}), 32'd0);
        resetb = 1'b1;
        repeat (2) @(negedge slow_clock);
        check("idle_no_start", 32'({busy_a, done_a, strb_a}), 32'd0);

        foreach (vecs[i]) run_round(vecs[i]);

        // Auto-restart: DONE lasts HOLD_CYCLES, then one clear pulse and lights drop
        dpb.pscore = 4'd9;
        dpb.dscore = 4'd0;
        start_b    = 1'b1;
        @(posedge slow_clock); #1;
        start_b = 1'b0;
        repeat (7) @(posedge slow_clock);
        hold = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge slow_clock);
            if (done_b && !dpb.clear_hands) hold++;
            else break;
        end
        check("auto_hold_cycles", 32'(hold), 32'd4);
        check("auto_clear_pulse", 32'(dpb.clear_hands), 32'd1);
        check("auto_light_held", 32'({pl_b, dl_b}), 32'b10);
        check("auto_tallies", 32'({pw_b, rn_b}), 32'h0101);
        @(negedge slow_clock);
        check("auto_clear_once", 32'(dpb.clear_hands), 32'd0);
        check("auto_lights_drop", 32'({pl_b, dl_b, dpb.load_pcard1}), 32'b001);

        // Start held in DONE chains straight into CLEAR, then a reset lands in BANKER
        @(posedge slow_clock); #1;
        start_a = 1'b1;
        @(posedge slow_clock); #1;
        check("chain_clear", 32'({dpa.clear_hands, busy_a, done_a}), 32'b110);
        @(posedge slow_clock); #1;
        check("chain_p1_lights_off", 32'({dpa.load_pcard1, pl_a, dl_a}), 32'b100);
        start_a    = 1'b0;
        dpa.pscore = 4'd2;
        dpa.dscore = 4'd3;
        dpa.pcard3 = 4'd0;
        repeat (4) @(posedge slow_clock); #1;
        check("eval_load_pcard3", 32'(strb_a), 32'b0000100);
        @(posedge slow_clock); #1;
        check("banker_load_dcard3", 32'({strb_a, busy_a}), 32'b00000101);
        #2;
        resetb = 1'b0;
        #1;
        check("midreset_strobes", 32'(strb_a), 32'd0);
        check("midreset_flags", 32'({pl_a, dl_a, busy_a, done_a}), 32'd0);
        check("midreset_tallies", 32'({pw_a, dw_a, ti_a, rn_a}), 32'd0);
        @(negedge slow_clock);
        resetb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge slow_clock);
            check("idle_after_reset", 32'({busy_a, done_a, strb_a}), 32'd0);
        end

        // Tally clear coincident with SETTLE wins over the increment
        dpa.pscore = 4'd9;
        dpa.dscore = 4'd0;
        start_a    = 1'b1;
        @(posedge slow_clock); #1;
        start_a = 1'b0;
        repeat (6) @(posedge slow_clock); #1;
        tally_clr_a = 1'b1;
        @(posedge slow_clock); #1;
        tally_clr_a = 1'b0;
        check("clr_settle_tallies", 32'({pw_a, dw_a, ti_a, rn_a}), 32'd0);
        check("clr_settle_state", 32'({pl_a, dl_a, done_a}), 32'b101);
        start_a = 1'b1;
        @(posedge slow_clock); #1;
        start_a = 1'b0;
        repeat (7) @(posedge slow_clock); #1;
        check("post_clr_count", 32'({pw_a, dw_a, ti_a, rn_a}), 32'b01000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baccarat_round_ctrl.md
Name: baccarat_round_ctrl

Overview:
Multi-round successor to the single-hand baccarat dealer state machine.
- Sequences the deal (P1, D1, P2, D2), applies natural, stand and third-card rules, and settles the winner.
- Holds the result, then starts the next round on request or automatically after a programmable hold.
- Keeps saturating win/tie/round tallies.
- Sits between the card/score datapath (card registers plus mod-10 scorers) and the board LEDs/HEX display logic.

Parameters:
CNT_W, 8, width of each tally counter
AUTO_RESTART, 0, 1 = leave DONE automatically after HOLD_CYCLES; 0 = wait for start
HOLD_CYCLES, 4, cycles spent in DONE before auto restart (must be at least 1)

Ports:
slow_clock  in  1  clock; all state changes on rising edge
resetb  in  1  reset; asynchronous, active-low
start  in  1  level-sampled request to begin a round (IDLE/DONE only)
tally_clr  in  1  synchronous clear of all tallies
pscore  in  4  player hand score 0-9 from datapath
dscore  in  4  dealer hand score 0-9 from datapath
pcard3  in  4  value 0-9 of player third card
load_pcard1, load_pcard2, load_pcard3  out  1 each  card-register load enables
load_dcard1, load_dcard2, load_dcard3  out  1 each  card-register load enables
clear_hands  out  1  one-cycle pulse zeroing all six card registers
player_win_light, dealer_win_light  out  1 each  result; both high = tie
busy  out  1  high from CLEAR through SETTLE
round_done  out  1  high while in DONE
player_wins, dealer_wins, ties, rounds  out  CNT_W each  tallies

Behaviour:
- Reset (resetb=0, async): state IDLE; all load strobes, clear_hands, lights, busy and round_done are 0; all tallies are 0.
- Load strobes and clear_hands are combinational from state and inputs. A card register captures on the edge that ends the strobed cycle. Scores reflecting that card are valid in the next cycle.
- Lights, tallies and state are registered.
- States and transitions:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: clear_hands=1, lights<=0 -> P1.
  - P1: load_pcard1 -> D1.
  - D1: load_dcard1 -> P2.
  - P2: load_pcard2 -> D2.
  - D2: load_dcard2 -> EVAL.
  - EVAL, natural (pscore>=8 or dscore>=8) -> SETTLE, no draw.
  - EVAL, both pscore and dscore in 6-7 -> SETTLE.
  - EVAL, pscore in 6-7 and dscore<=5 -> load_dcard3 -> SETTLE.
  - EVAL, pscore<=5 -> load_pcard3 -> BANKER.
  - BANKER: load_dcard3 and go to SETTLE if any of the following holds; otherwise go to SETTLE with no draw:
    - dscore<=2
    - dscore==3 and pcard3!=8
    - dscore==4 and pcard3 in 2-7
    - dscore==5 and pcard3 in 4-7
    - dscore==6 and pcard3 in 6-7
  - SETTLE: compare scores; pscore>dscore -> player light; dscore>pscore -> dealer light; equal -> both. Matching tally +1 and rounds +1, exactly once per round -> DONE.
  - DONE: lights held. AUTO_RESTART=0: start=1 -> CLEAR. AUTO_RESTART=1: hold counter loaded on entry; CLEAR after exactly HOLD_CYCLES cycles in DONE (start ignored).
- Round length with no third cards: CLEAR to DONE entry is 7 cycles.
- Tallies saturate at 2^CNT_W-1; no wrap.
- tally_clr=1 zeroes all tallies on the next edge and overrides a coincident SETTLE increment. State and lights are unaffected.
- start is ignored outside IDLE/DONE. Holding start high in DONE with AUTO_RESTART=0 chains rounds back-to-back.
- Reset asserted mid-round aborts immediately to IDLE; no partial tally update.
- Unused state encodings recover to IDLE with all outputs 0.
- At most one load strobe is high in any cycle.

Test Plan:
- Reset, then start pulse, datapath gives pscore=9 at EVAL, dscore=3 -> no third-card strobes; player_win_light=1, dealer_win_light=0; player_wins=1, rounds=1; round_done after 7 cycles.
- pscore=4, then pcard3=8 with dscore=3 in BANKER -> load_pcard3 one cycle, no load_dcard3; SETTLE with pscore=2, dscore=3 -> dealer light, dealer_wins=1.
- pscore=7, dscore=5 at EVAL -> load_dcard3 only; SETTLE with dscore=7 -> both lights, ties=1.
- CNT_W=2, 5 player wins -> player_wins sticks at 3, rounds stays 3; tally_clr in the same cycle as a SETTLE -> all tallies 0.
- AUTO_RESTART=1, HOLD_CYCLES=4 -> DONE lasts exactly 4 cycles, then clear_hands pulses once and the lights drop.
- resetb low during BANKER -> all outputs 0 immediately (before the next edge); IDLE persists with start=0; tallies 0.
